// File: rtl/regfile_scb.sv
// Multi-read-port register file with write-first bypass, byte-enable
// writeback and a per-register pending-write scoreboard. Decode reads
// operands and issues destinations; writeback retires them. The scoreboard
// lets decode see RAW hazards (rd_pend) and stalls WAW hazards (iss_ready).
module regfile_scb #(
    parameter int DATA_W   = 32,
    parameter int ADDR_W   = 5,
    parameter int NUM_RD   = 2,
    parameter int ZERO_REG = 1
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic [NUM_RD*ADDR_W-1:0] rd_addr,
    output logic [NUM_RD*DATA_W-1:0] rd_data,
    output logic [NUM_RD-1:0]        rd_pend,
    input  logic                     wb_en,
    input  logic [ADDR_W-1:0]        wb_addr,
    input  logic [DATA_W-1:0]        wb_data,
    input  logic [DATA_W/8-1:0]      wb_be,
    input  logic                     iss_valid,
    input  logic [ADDR_W-1:0]        iss_addr,
    output logic                     iss_ready,
    output logic                     busy_any,
    output logic [ADDR_W:0]          pend_cnt
);

    localparam int DEPTH = 1 << ADDR_W;
    localparam int NB    = DATA_W / 8;
    localparam int CNT_W = ADDR_W + 1;

    // Register storage: cleared by reset, so it lives in flops.
    logic [DATA_W-1:0] mem_q [DEPTH];

    // Scoreboard state.
    logic [DEPTH-1:0]  pend_q;
    logic [DEPTH-1:0]  pend_d;
    logic [CNT_W-1:0]  pend_cnt_q;
    logic [CNT_W-1:0]  pend_cnt_d;
    logic              busy_q;
    logic              busy_d;

    // Writeback decode.
    logic              wb_zero;
    logic              wb_wr;
    logic [DATA_W-1:0] wb_merged;

    // Issue decode.
    logic              iss_zero;
    logic              iss_set;
    logic              cnt_inc;
    logic              cnt_dec;

    // Register 0 is hard-wired when ZERO_REG is set: never written, never pending.
    assign wb_zero  = (ZERO_REG != 0) && (wb_addr == '0);
    assign iss_zero = (ZERO_REG != 0) && (iss_addr == '0);
    assign wb_wr    = wb_en & ~wb_zero;

    // Byte merge of the incoming write with the current contents of the
    // destination; shared by the store path and the read bypass.
    genvar gi;
    generate
        for (gi = 0; gi < NB; gi++) begin : g_merge
            assign wb_merged[gi*8 +: 8] = wb_be[gi] ? wb_data[gi*8 +: 8]
                                                    : mem_q[wb_addr][gi*8 +: 8];
        end
    endgenerate

    // Storage update: only enabled bytes change; suppressed writes to r0 drop out.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
        end else if (wb_wr) begin
            mem_q[wb_addr] <= wb_merged;
        end
    end

    // Read ports: r0 forced to zero, then write-first bypass, then storage.
    // A writeback in the same cycle also hides the pending bit of its target.
    generate
        for (gi = 0; gi < NUM_RD; gi++) begin : g_rd
            logic [ADDR_W-1:0] ra;
            logic              wb_hit;

            assign ra     = rd_addr[gi*ADDR_W +: ADDR_W];
            assign wb_hit = wb_en && (wb_addr == ra);

            assign rd_data[gi*DATA_W +: DATA_W] =
                ((ZERO_REG != 0) && (ra == '0)) ? '0 :
                (wb_hit && wb_wr)               ? wb_merged :
                                                  mem_q[ra];
            assign rd_pend[gi] = pend_q[ra] & ~wb_hit;
        end
    endgenerate

    // Issue is stalled only by an outstanding write to the same destination
    // that is not being retired this very cycle. Independent of iss_valid.
    assign iss_ready = ~pend_q[iss_addr] | (wb_en && (wb_addr == iss_addr)) | iss_zero;
    assign iss_set   = iss_valid & iss_ready & ~iss_zero;

    // Next pending bit per register: a new issue wins over a same-cycle
    // writeback, otherwise a writeback retires the entry.
    generate
        for (gi = 0; gi < DEPTH; gi++) begin : g_pend
            if ((ZERO_REG != 0) && (gi == 0)) begin : g_zero
                assign pend_d[gi] = 1'b0;
            end else begin : g_reg
                assign pend_d[gi] = (iss_set && (iss_addr == ADDR_W'(gi))) |
                                    (pend_q[gi] & ~(wb_en && (wb_addr == ADDR_W'(gi))));
            end
        end
    endgenerate

    // Occupancy count: an accepted issue always lands on a bit that is free
    // or being freed, so it is a clean +1; a writeback is -1 only when it
    // retires a set bit. Same-register issue+writeback nets to zero.
    always_comb begin
        cnt_inc    = iss_set;
        cnt_dec    = wb_en & pend_q[wb_addr];
        pend_cnt_d = pend_cnt_q + CNT_W'(cnt_inc) - CNT_W'(cnt_dec);
        busy_d     = (pend_cnt_d != '0);
    end

    // Scoreboard registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pend_q     <= '0;
            pend_cnt_q <= '0;
            busy_q     <= 1'b0;
        end else begin
            pend_q     <= pend_d;
            pend_cnt_q <= pend_cnt_d;
            busy_q     <= busy_d;
        end
    end

    assign pend_cnt = pend_cnt_q;
    assign busy_any = busy_q;

endmodule

// File: tb/tb_regfile_scb.sv
// Randomised and directed bench for regfile_scb (32x32, two read ports,
// hard-wired r0). A behavioural model of registers and pending flags is
// kept here and all outputs are compared against it every cycle.
module tb_regfile_scb;

    logic        clk;
    logic        rst_n;
    logic [9:0]  rd_addr;
    logic [63:0] rd_data;
    logic [1:0]  rd_pend;
    logic        wb_en;
    logic [4:0]  wb_addr;
    logic [31:0] wb_data;
    logic [3:0]  wb_be;
    logic        iss_valid;
    logic [4:0]  iss_addr;
    logic        iss_ready;
    logic        busy_any;
    logic [5:0]  pend_cnt;

    int n_checks = 0;
    int n_errors = 0;
    int cyc = 0;

    // Reference state.
    logic [31:0] m_mem [32];
    bit          m_pend [32];

    regfile_scb #(.DATA_W(32), .ADDR_W(5), .NUM_RD(2), .ZERO_REG(1)) dut (
        .clk(clk), .rst_n(rst_n),
        .rd_addr(rd_addr), .rd_data(rd_data), .rd_pend(rd_pend),
        .wb_en(wb_en), .wb_addr(wb_addr), .wb_data(wb_data), .wb_be(wb_be),
        .iss_valid(iss_valid), .iss_addr(iss_addr), .iss_ready(iss_ready),
        .busy_any(busy_any), .pend_cnt(pend_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] d,
                                          input logic [3:0] be);
        logic [31:0] r;
        r = old;
        for (int b = 0; b < 4; b++) if (be[b]) r[b*8 +: 8] = d[b*8 +: 8];
        return r;
    endfunction

    function automatic logic [31:0] exp_rd(input logic [4:0] a);
        if (a == 0) return 32'h0;
        if (wb_en && wb_addr == a) return merge(m_mem[a], wb_data, wb_be);
        return m_mem[a];
    endfunction

    function automatic int pend_count();
        int n = 0;
        for (int r = 0; r < 32; r++) n += int'(m_pend[r]);
        return n;
    endfunction

    function automatic logic exp_ready();
        return !m_pend[iss_addr] || (wb_en && wb_addr == iss_addr);
    endfunction

    task automatic model_reset();
        for (int r = 0; r < 32; r++) begin
            m_mem[r]  = 32'h0;
            m_pend[r] = 1'b0;
        end
    endtask

    // Apply one clock edge to the model using the inputs currently driven.
    task automatic model_update();
        logic acc;
        acc = iss_valid && exp_ready();
        if (wb_en && wb_addr != 0) m_mem[wb_addr] = merge(m_mem[wb_addr], wb_data, wb_be);
        if (wb_en) m_pend[wb_addr] = 1'b0;
        if (acc && iss_addr != 0) m_pend[iss_addr] = 1'b1;
    endtask

    task automatic check_outputs();
        logic [4:0] a;
        for (int k = 0; k < 2; k++) begin
            a = rd_addr[k*5 +: 5];
            check_val($sformatf("rd_data%0d", k), {32'h0, rd_data[k*32 +: 32]}, {32'h0, exp_rd(a)});
            check_val($sformatf("rd_pend%0d", k), {63'h0, rd_pend[k]},
                      {63'h0, m_pend[a] && !(wb_en && wb_addr == a)});
        end
        check_val("iss_ready", {63'h0, iss_ready}, {63'h0, exp_ready()});
        check_val("pend_cnt", {58'h0, pend_cnt}, 64'(pend_count()));
        check_val("busy_any", {63'h0, busy_any}, {63'h0, pend_count() != 0});
    endtask

    task automatic drive(input logic we, input logic [4:0] wa, input logic [31:0] wd,
                         input logic [3:0] be, input logic iv, input logic [4:0] ia,
                         input logic [4:0] ra0, input logic [4:0] ra1);
        wb_en = we; wb_addr = wa; wb_data = wd; wb_be = be;
        iss_valid = iv; iss_addr = ia; rd_addr = {ra1, ra0};
    endtask

    // Called at posedge+1 with inputs driven: check mid-cycle, then advance.
    task automatic tick();
        @(negedge clk);
        check_outputs();
        $display("cyc %0d wb=%b@%0d be=%h iss=%b@%0d rdy=%b ra=%0d/%0d rd=%h/%h pend=%b cnt=%0d",
                 cyc, wb_en, wb_addr, wb_be, iss_valid, iss_addr, iss_ready,
                 rd_addr[4:0], rd_addr[9:5], rd_data[31:0], rd_data[63:32], rd_pend, pend_cnt);
        @(posedge clk);
        model_update();
        cyc++;
        #1;
    endtask

    task automatic idle(input logic [4:0] ra0);
        drive(1'b0, 5'd0, 32'h0, 4'h0, 1'b0, 5'd0, ra0, 5'd0);
    endtask

    initial begin
        rst_n = 1'b0;
        model_reset();
        idle(5'd0);
        repeat (2) @(posedge clk);
        #1;
        check_val("reset_rd", {32'h0, rd_data[31:0]}, 64'h0);
        check_val("reset_cnt", {58'h0, pend_cnt}, 64'h0);
        check_val("reset_busy", {63'h0, busy_any}, 64'h0);
        #3 rst_n = 1'b1;
        @(posedge clk);
        #1;

        // Write-first bypass, then the stored value.
        drive(1'b1, 5'd5, 32'hDEADBEEF, 4'hF, 1'b0, 5'd0, 5'd5, 5'd0);
        #1 check_val("bypass", {32'h0, rd_data[31:0]}, 64'hDEADBEEF);
        tick();
        idle(5'd5);
        #1 check_val("bypass_held", {32'h0, rd_data[31:0]}, 64'hDEADBEEF);
        tick();

        // Byte-enable merge.
        drive(1'b1, 5'd7, 32'h11223344, 4'hF, 1'b0, 5'd0, 5'd7, 5'd0);
        tick();
        drive(1'b1, 5'd7, 32'hAABBCCDD, 4'b0101, 1'b0, 5'd0, 5'd7, 5'd7);
        tick();
        idle(5'd7);
        #1 check_val("byte_en", {32'h0, rd_data[31:0]}, 64'h11BB33DD);
        tick();

        // Register 0: writes dropped, issue accepted but not tracked.
        drive(1'b1, 5'd0, 32'hFFFFFFFF, 4'hF, 1'b1, 5'd0, 5'd0, 5'd0);
        #1 check_val("r0_ready", {63'h0, iss_ready}, 64'h1);
        check_val("r0_bypass", {32'h0, rd_data[31:0]}, 64'h0);
        tick();
        idle(5'd0);
        #1 check_val("r0_cnt", {58'h0, pend_cnt}, 64'h0);
        check_val("r0_rd", {32'h0, rd_data[31:0]}, 64'h0);
        tick();

        // Scoreboard: issue, WAW stall, writeback with re-issue.
        drive(1'b0, 5'd0, 32'h0, 4'h0, 1'b1, 5'd3, 5'd3, 5'd0);
        tick();
        #1 check_val("sb_pend", {63'h0, rd_pend[0]}, 64'h1);
        check_val("sb_cnt", {58'h0, pend_cnt}, 64'h1);
        check_val("sb_busy", {63'h0, busy_any}, 64'h1);
        check_val("sb_stall", {63'h0, iss_ready}, 64'h0);
        tick();
        tick();
        drive(1'b1, 5'd3, 32'h12345678, 4'hF, 1'b1, 5'd3, 5'd3, 5'd0);
        #1 check_val("sb_reissue_rdy", {63'h0, iss_ready}, 64'h1);
        tick();
        idle(5'd3);
        #1 check_val("sb_reissue_cnt", {58'h0, pend_cnt}, 64'h1);
        check_val("sb_reissue_pend", {63'h0, rd_pend[0]}, 64'h1);
        tick();
        drive(1'b1, 5'd3, 32'h0BADF00D, 4'hF, 1'b0, 5'd0, 5'd3, 5'd0);
        tick();

        // Fill every architectural register, then drain.
        for (int r = 1; r < 32; r++) begin
            drive(1'b0, 5'd0, 32'h0, 4'h0, 1'b1, 5'(r), 5'(r), 5'(r - 1));
            tick();
        end
        idle(5'd1);
        #1 check_val("fill_cnt", {58'h0, pend_cnt}, 64'd31);
        check_val("fill_busy", {63'h0, busy_any}, 64'h1);
        for (int r = 1; r < 32; r++) begin
            drive(1'b1, 5'(r), $urandom, 4'hF, 1'b0, 5'd0, 5'(r), 5'($urandom_range(0, 31)));
            tick();
        end
        idle(5'd0);
        #1 check_val("drain_cnt", {58'h0, pend_cnt}, 64'd0);
        check_val("drain_busy", {63'h0, busy_any}, 64'h0);
        tick();

        // Random traffic concentrated on a few registers to provoke hazards.
        for (int i = 0; i < 600; i++) begin
            logic [4:0] wa, ia;
            wa = ($urandom_range(0, 3) == 0) ? 5'($urandom_range(0, 31)) : 5'($urandom_range(0, 7));
            ia = ($urandom_range(0, 3) == 0) ? 5'($urandom_range(0, 31)) : 5'($urandom_range(0, 7));
            drive(1'($urandom_range(0, 1)), wa, $urandom, 4'($urandom_range(0, 15)),
                  1'($urandom_range(0, 1)), ia,
                  5'($urandom_range(0, 7)), 5'($urandom_range(0, 31)));
            tick();
        end

        // Asynchronous reset in the middle of a cycle with entries pending.
        for (int r = 8; r < 13; r++) begin
            drive(1'b0, 5'd0, 32'h0, 4'h0, 1'b1, 5'(r), 5'(r), 5'd7);
            tick();
        end
        drive(1'b0, 5'd0, 32'h0, 4'h0, 1'b0, 5'd9, 5'd7, 5'd10);
        #1 rst_n = 1'b0;
        #1;
        check_val("mid_rst_rd0", {32'h0, rd_data[31:0]}, 64'h0);
        check_val("mid_rst_rd1", {32'h0, rd_data[63:32]}, 64'h0);
        check_val("mid_rst_pend", {62'h0, rd_pend}, 64'h0);
        check_val("mid_rst_cnt", {58'h0, pend_cnt}, 64'h0);
        check_val("mid_rst_busy", {63'h0, busy_any}, 64'h0);
        check_val("mid_rst_rdy", {63'h0, iss_ready}, 64'h1);
        model_reset();
        #1 rst_n = 1'b1;
        @(posedge clk);
        #1;
        for (int i = 0; i < 60; i++) begin
            drive(1'($urandom_range(0, 1)), 5'($urandom_range(0, 7)), $urandom,
                  4'($urandom_range(0, 15)), 1'($urandom_range(0, 1)),
                  5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)));
            tick();
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
